// File: rtl/mips_prefetch_ifu_if.sv
// ============================================================================
// mips_prefetch_ifu_if : fetch-unit bus (imem, decode handshake, redirect)
// Revision: 1.0
// ============================================================================
`default_nettype none

interface mips_prefetch_ifu_if #(
   parameter int ADDR_W = 30
) ();
   logic              imem_req;
   logic [ADDR_W+1:0] imem_addr;
   logic [31:0]       imem_rdata;
   logic              out_valid;
   logic              out_ready;
   logic [31:0]       out_inst;
   logic [ADDR_W-1:0] out_pc;
   logic              redir_br;
   logic              redir_j;
   logic              redir_jr;
   logic [ADDR_W-1:0] redir_pc;
   logic [15:0]       imm16;
   logic [25:0]       imm26;
   logic [31:0]       busa;
   logic [ADDR_W-1:0] fetch_pc;

   modport master (
      output imem_req, imem_addr, out_valid, out_inst, out_pc, fetch_pc,
      input  imem_rdata, out_ready, redir_br, redir_j, redir_jr, redir_pc,
             imm16, imm26, busa
   );

   modport slave (
      input  imem_req, imem_addr, out_valid, out_inst, out_pc, fetch_pc,
      output imem_rdata, out_ready, redir_br, redir_j, redir_jr, redir_pc,
             imm16, imm26, busa
   );
endinterface

`default_nettype wire

// File: rtl/mips_prefetch_ifu.sv
// ============================================================================
// mips_prefetch_ifu : pipelined fetch unit with DEPTH-entry prefetch queue
// Revision: 1.0
// ============================================================================
`default_nettype none

module mips_prefetch_ifu #(
   parameter int                ADDR_W   = 30,
   parameter int                DEPTH    = 4,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  wire                       clk,
   input  wire                       reset,
   mips_prefetch_ifu_if.master       bus
);
   localparam int C_PTR_W = $clog2(DEPTH);
   localparam int C_CNT_W = $clog2(DEPTH + 1);

   logic [ADDR_W-1:0]  fetch_pc_q, fetch_pc_d;
   logic [ADDR_W-1:0]  req_pc_q, req_pc_d;
   logic               inflight_q, inflight_d;
   logic [C_PTR_W-1:0] head_q, head_d, tail_q, tail_d;
   logic [C_CNT_W-1:0] count_q, count_d;
   logic [31:0]        inst_q [DEPTH];
   logic [ADDR_W-1:0]  pc_q   [DEPTH];

   logic               w_any_redir;
   logic               w_issue;
   logic               w_push;
   logic               w_pop;
   logic [ADDR_W-1:0]  w_target;
   logic               w_unused;

   assign w_unused    = ^bus.busa[1:0];
   assign w_any_redir = bus.redir_br | bus.redir_j | bus.redir_jr;
   // Gating with reset keeps imem_req low while reset is held.
   assign w_issue     = reset & ~w_any_redir &
                        (({1'b0, count_q} + (C_CNT_W+1)'(inflight_q)) < (C_CNT_W+1)'(DEPTH));
   assign w_push      = inflight_q & ~w_any_redir;
   assign w_pop       = (count_q != '0) & bus.out_ready;

   always_comb begin
      w_target = bus.redir_pc + ADDR_W'(1) + {{(ADDR_W-16){bus.imm16[15]}}, bus.imm16};
      if (bus.redir_jr)
         w_target = bus.busa[ADDR_W+1:2];
      else if (bus.redir_j)
         w_target = {bus.redir_pc[ADDR_W-1:26], bus.imm26};
   end

   always_comb begin
      fetch_pc_d = fetch_pc_q;
      req_pc_d   = req_pc_q;
      inflight_d = w_issue;
      head_d     = head_q;
      tail_d     = tail_q;
      count_d    = count_q;
      if (w_any_redir) begin
         fetch_pc_d = w_target;
         head_d     = '0;
         tail_d     = '0;
         count_d    = '0;
      end else begin
         if (w_issue) begin
            fetch_pc_d = fetch_pc_q + ADDR_W'(1);
            req_pc_d   = fetch_pc_q;
         end
         head_d  = head_q + C_PTR_W'(w_pop);
         tail_d  = tail_q + C_PTR_W'(w_push);
         count_d = count_q + C_CNT_W'(w_push) - C_CNT_W'(w_pop);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         fetch_pc_q <= RESET_PC;
         req_pc_q   <= '0;
         inflight_q <= 1'b0;
         head_q     <= '0;
         tail_q     <= '0;
         count_q    <= '0;
      end else begin
         fetch_pc_q <= fetch_pc_d;
         req_pc_q   <= req_pc_d;
         inflight_q <= inflight_d;
         head_q     <= head_d;
         tail_q     <= tail_d;
         count_q    <= count_d;
      end
   end

   // Slot storage is cleared on reset so the head reads zero out of reset.
   for (genvar i = 0; i < DEPTH; i++) begin : g_slot
      always_ff @(posedge clk or negedge reset) begin
         if (!reset) begin
            inst_q[i] <= '0;
            pc_q[i]   <= '0;
         end else if (w_push && (tail_q == C_PTR_W'(i))) begin
            inst_q[i] <= bus.imem_rdata;
            pc_q[i]   <= req_pc_q;
         end
      end
   end

   assign bus.imem_req  = w_issue;
   assign bus.imem_addr = {fetch_pc_q, 2'b00};
   assign bus.out_valid = (count_q != '0);
   assign bus.out_inst  = inst_q[head_q];
   assign bus.out_pc    = pc_q[head_q];
   assign bus.fetch_pc  = fetch_pc_q;

endmodule

`default_nettype wire

// File: tb/tb_mips_prefetch_ifu.sv
// ============================================================================
// tb_mips_prefetch_ifu : directed self-checking bench for mips_prefetch_ifu
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_mips_prefetch_ifu;
   localparam int                ADDR_W   = 30;
   localparam int                DEPTH    = 4;
   localparam logic [ADDR_W-1:0] RESET_PC = '0;

   logic clk   = 1'b0;
   logic reset = 1'b0;
   int   n_checks = 0;
   int   n_fail   = 0;

   mips_prefetch_ifu_if #(.ADDR_W(ADDR_W)) bus ();

   mips_prefetch_ifu #(
      .ADDR_W   (ADDR_W),
      .DEPTH    (DEPTH),
      .RESET_PC (RESET_PC)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] memf(input logic [ADDR_W-1:0] a);
      return ({2'b00, a} * 32'h9E37_79B1) ^ 32'h1234_5678;
   endfunction

   // 1-cycle-latency instruction memory
   always @(posedge clk) bus.imem_rdata <= memf(bus.imem_addr[ADDR_W+1:2]);

   task automatic clear_redir();
      bus.redir_br = 0; bus.redir_j = 0; bus.redir_jr = 0;
      bus.redir_pc = '0; bus.imm16 = '0; bus.imm26 = '0; bus.busa = '0;
   endtask

   task automatic apply_reset(input logic rdy);
      @(negedge clk);
      reset = 0;
      clear_redir();
      bus.out_ready = rdy;
      repeat (2) @(negedge clk);
      reset = 1;
      #1;
   endtask

   task automatic next_cycle();
      @(negedge clk);
      #1;
   endtask

   task automatic test_reset();
      #1;
      n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid got %h exp 0", bus.out_valid); end
      n_checks++; if (bus.imem_req !== 1'b0) begin n_fail++; $display("FAIL rst_req got %h exp 0", bus.imem_req); end
      n_checks++; if (bus.out_inst !== 32'h0) begin n_fail++; $display("FAIL rst_inst got %h exp 0", bus.out_inst); end
      n_checks++; if (bus.out_pc !== '0) begin n_fail++; $display("FAIL rst_pc got %h exp 0", bus.out_pc); end
      n_checks++; if (bus.fetch_pc !== RESET_PC) begin n_fail++; $display("FAIL rst_fetch_pc got %h exp %h", bus.fetch_pc, RESET_PC); end
   endtask

   task automatic test_stream();
      apply_reset(1'b1);
      n_checks++; if (bus.imem_req !== 1'b1) begin n_fail++; $display("FAIL stream_req0 got %h exp 1", bus.imem_req); end
      n_checks++; if (bus.imem_addr !== 32'h0) begin n_fail++; $display("FAIL stream_addr0 got %h exp 0", bus.imem_addr); end
      for (int c = 1; c < 10; c++) begin
         next_cycle();
         if (c == 1) begin
            n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL stream_valid_c1 got %h exp 0", bus.out_valid); end
         end else begin
            n_checks++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL stream_valid c%0d got %h exp 1", c, bus.out_valid); end
            n_checks++; if (bus.out_pc !== ADDR_W'(c - 2)) begin n_fail++; $display("FAIL stream_pc c%0d got %h exp %h", c, bus.out_pc, c - 2); end
            n_checks++; if (bus.out_inst !== memf(ADDR_W'(c - 2))) begin n_fail++; $display("FAIL stream_inst c%0d got %h exp %h", c, bus.out_inst, memf(ADDR_W'(c - 2))); end
         end
      end
   endtask

   task automatic test_full();
      apply_reset(1'b0);
      repeat (10) next_cycle();
      n_checks++; if (bus.imem_req !== 1'b0) begin n_fail++; $display("FAIL full_req got %h exp 0", bus.imem_req); end
      n_checks++; if (bus.fetch_pc !== ADDR_W'(4)) begin n_fail++; $display("FAIL full_fetch_pc got %h exp 4", bus.fetch_pc); end
      bus.out_ready = 1;
      for (int k = 0; k < 8; k++) begin
         if (k > 0) next_cycle();
         n_checks++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL drain_valid k%0d got %h exp 1", k, bus.out_valid); end
         n_checks++; if (bus.out_pc !== ADDR_W'(k)) begin n_fail++; $display("FAIL drain_pc k%0d got %h exp %h", k, bus.out_pc, k); end
         n_checks++; if (bus.out_inst !== memf(ADDR_W'(k))) begin n_fail++; $display("FAIL drain_inst k%0d got %h exp %h", k, bus.out_inst, memf(ADDR_W'(k))); end
      end
   endtask

   task automatic test_branch();
      apply_reset(1'b1);
      repeat (5) next_cycle();
      bus.redir_br = 1; bus.redir_pc = ADDR_W'(32'h10); bus.imm16 = 16'hFFFC;
      #1;
      n_checks++; if (bus.imem_req !== 1'b0) begin n_fail++; $display("FAIL br_req_R got %h exp 0", bus.imem_req); end
      @(negedge clk); clear_redir(); #1;
      n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL br_valid_R1 got %h exp 0", bus.out_valid); end
      n_checks++; if (bus.fetch_pc !== ADDR_W'(32'h0D)) begin n_fail++; $display("FAIL br_target got %h exp 0d", bus.fetch_pc); end
      n_checks++; if (bus.imem_req !== 1'b1) begin n_fail++; $display("FAIL br_req_R1 got %h exp 1", bus.imem_req); end
      next_cycle();
      n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL br_valid_R2 got %h exp 0", bus.out_valid); end
      next_cycle();
      n_checks++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL br_valid_R3 got %h exp 1", bus.out_valid); end
      n_checks++; if (bus.out_pc !== ADDR_W'(32'h0D)) begin n_fail++; $display("FAIL br_pc_R3 got %h exp 0d", bus.out_pc); end
      n_checks++; if (bus.out_inst !== memf(ADDR_W'(32'h0D))) begin n_fail++; $display("FAIL br_inst_R3 got %h exp %h", bus.out_inst, memf(ADDR_W'(32'h0D))); end
      next_cycle();
      n_checks++; if (bus.out_pc !== ADDR_W'(32'h0E)) begin n_fail++; $display("FAIL br_pc_R4 got %h exp 0e", bus.out_pc); end
   endtask

   task automatic test_jump();
      @(negedge clk);
      bus.redir_j = 1; bus.redir_jr = 1; bus.busa = 32'h0000_0100;
      bus.imm26 = 26'h123; bus.redir_pc = ADDR_W'(32'h3C00_0000);
      @(negedge clk); clear_redir(); #1;
      n_checks++; if (bus.fetch_pc !== ADDR_W'(32'h40)) begin n_fail++; $display("FAIL jr_prio got %h exp 40", bus.fetch_pc); end
      @(negedge clk);
      bus.redir_j = 1; bus.imm26 = 26'h123; bus.redir_pc = ADDR_W'(32'h3C00_0000);
      @(negedge clk); clear_redir(); #1;
      n_checks++; if (bus.fetch_pc !== ADDR_W'(32'h3C00_0123)) begin n_fail++; $display("FAIL j_target got %h exp 3c000123", bus.fetch_pc); end
      n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL j_valid_R1 got %h exp 0", bus.out_valid); end
      repeat (2) next_cycle();
      n_checks++; if (bus.out_pc !== ADDR_W'(32'h3C00_0123)) begin n_fail++; $display("FAIL j_pc_R3 got %h exp 3c000123", bus.out_pc); end
   endtask

   task automatic test_wrap();
      @(negedge clk);
      bus.redir_jr = 1; bus.busa = 32'hFFFF_FFFC;
      @(negedge clk); clear_redir(); #1;
      n_checks++; if (bus.fetch_pc !== ADDR_W'(32'h3FFF_FFFF)) begin n_fail++; $display("FAIL wrap_fetch_top got %h exp 3fffffff", bus.fetch_pc); end
      n_checks++; if (bus.imem_addr !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wrap_addr_top got %h exp fffffffc", bus.imem_addr); end
      next_cycle();
      n_checks++; if (bus.fetch_pc !== '0) begin n_fail++; $display("FAIL wrap_fetch_zero got %h exp 0", bus.fetch_pc); end
      next_cycle();
      n_checks++; if (bus.out_pc !== ADDR_W'(32'h3FFF_FFFF)) begin n_fail++; $display("FAIL wrap_pc_top got %h exp 3fffffff", bus.out_pc); end
      next_cycle();
      n_checks++; if (bus.out_pc !== '0) begin n_fail++; $display("FAIL wrap_pc_zero got %h exp 0", bus.out_pc); end
      bus.redir_br = 1; bus.redir_pc = ADDR_W'(32'h3FFF_FFFE); bus.imm16 = 16'h0003;
      @(negedge clk); clear_redir(); #1;
      n_checks++; if (bus.fetch_pc !== ADDR_W'(2)) begin n_fail++; $display("FAIL wrap_br_target got %h exp 2", bus.fetch_pc); end
      repeat (2) next_cycle();
      n_checks++; if (bus.out_pc !== ADDR_W'(2)) begin n_fail++; $display("FAIL wrap_br_pc got %h exp 2", bus.out_pc); end
      n_checks++; if (bus.out_inst !== memf(ADDR_W'(2))) begin n_fail++; $display("FAIL wrap_br_inst got %h exp %h", bus.out_inst, memf(ADDR_W'(2))); end
   endtask

   task automatic test_async_reset();
      apply_reset(1'b0);
      repeat (4) next_cycle();
      n_checks++; if (bus.out_valid !== 1'b1 || bus.out_pc !== '0) begin n_fail++; $display("FAIL areset_pre got valid %h pc %h exp 1/0", bus.out_valid, bus.out_pc); end
      #2 reset = 0;
      #1;
      n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL areset_valid got %h exp 0", bus.out_valid); end
      n_checks++; if (bus.imem_req !== 1'b0) begin n_fail++; $display("FAIL areset_req got %h exp 0", bus.imem_req); end
      n_checks++; if (bus.out_inst !== 32'h0 || bus.out_pc !== '0) begin n_fail++; $display("FAIL areset_head got inst %h pc %h exp 0/0", bus.out_inst, bus.out_pc); end
      n_checks++; if (bus.fetch_pc !== RESET_PC) begin n_fail++; $display("FAIL areset_fetch_pc got %h exp %h", bus.fetch_pc, RESET_PC); end
      repeat (2) @(negedge clk);
      bus.out_ready = 1;
      reset = 1;
      #1;
      for (int c = 1; c < 6; c++) begin
         next_cycle();
         if (c == 1) begin
            n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL areset_stale got %h exp 0", bus.out_valid); end
         end else begin
            n_checks++; if (bus.out_pc !== ADDR_W'(c - 2) || bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL areset_pc c%0d got %h exp %h", c, bus.out_pc, c - 2); end
            n_checks++; if (bus.out_inst !== memf(ADDR_W'(c - 2))) begin n_fail++; $display("FAIL areset_inst c%0d got %h exp %h", c, bus.out_inst, memf(ADDR_W'(c - 2))); end
         end
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog expired");
      $fatal(1, "timeout");
   end

   initial begin
      clear_redir();
      bus.out_ready = 1;
      test_reset();
      test_stream();
      test_full();
      test_branch();
      test_jump();
      test_wrap();
      test_async_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
